mips_mem_responder: RTL

//  Memory responder for the multicycle MIPS core: services memread/memwrite/adr/writedata and returns memdata.

---
 rtl/mips_mem_pkg.sv | 13 +
 rtl/mips_mem_if.sv | 24 ++
 rtl/mips_mem_loader.sv | 72 +++++++
 rtl/mips_mem_responder.sv | 86 ++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory responder.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      LOAD,
      RELEASE,
      RUN
   } state_t;

   localparam logic [7:0] IO_ADDR_DEFAULT = 8'hFF;
   localparam int unsigned ST_COUNT_W = 16;

endpackage

// File: rtl/mips_mem_if.sv
// Core memory bus plus program-loader byte stream between core/loader and responder.
interface mips_mem_if #(
   parameter int unsigned WIDTH = 8
);
   logic             memread;
   logic             memwrite;
   logic [WIDTH-1:0] adr;
   logic [WIDTH-1:0] writedata;
   logic [WIDTH-1:0] memdata;
   logic             ld_valid;
   logic [7:0]       ld_data;
   logic             ld_last;
   logic             ld_ready;

   modport master (
      output memread, memwrite, adr, writedata, ld_valid, ld_data, ld_last,
      input  memdata, ld_ready
   );

   modport slave (
      input  memread, memwrite, adr, writedata, ld_valid, ld_data, ld_last,
      output memdata, ld_ready
   );
endinterface

// File: rtl/mips_mem_loader.sv
// LOAD/RELEASE/RUN sequencer: streams the program image into RAM, then releases the core.
module mips_mem_loader
   import mips_mem_pkg::*;
#(
   parameter int unsigned      WIDTH   = 8,
   parameter int unsigned      DEPTH   = 1 << WIDTH,
   parameter logic [WIDTH-1:0] IO_ADDR = WIDTH'(IO_ADDR_DEFAULT)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld_valid,
   input  logic [7:0]       ld_data,
   input  logic             ld_last,
   input  logic             memwrite,
   input  logic [WIDTH-1:0] adr,
   input  logic [WIDTH-1:0] writedata,
   output logic             ld_ready,
   output logic             cpu_reset,
   output state_t           state,
   output logic             ram_we,
   output logic [WIDTH-1:0] ram_addr,
   output logic [WIDTH-1:0] ram_wdata
);

   localparam logic [WIDTH-1:0] PTR_LAST = WIDTH'(DEPTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] ld_ptr_q, ld_ptr_d;
   logic             ld_ready_q, ld_ready_d;
   logic             cpu_reset_q, cpu_reset_d;
   logic             accept;

   always_comb begin
      accept   = (state_q == LOAD) && ld_valid && ld_ready_q;
      state_d  = state_q;
      ld_ptr_d = ld_ptr_q;
      case (state_q)
         LOAD: begin
            if (accept) ld_ptr_d = ld_ptr_q + WIDTH'(1);
            if ((accept && ld_last) || (ld_ptr_q == PTR_LAST)) state_d = RELEASE;
         end
         RELEASE: state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = LOAD;
      endcase
      // Ready drops once the pointer parks on the top byte, so the image never wraps.
      ld_ready_d  = (state_d == LOAD) && (ld_ptr_d != PTR_LAST);
      cpu_reset_d = (state_d != RUN);
      ram_we      = accept || ((state_q == RUN) && memwrite && (adr != IO_ADDR));
      ram_addr    = accept ? ld_ptr_q : adr;
      ram_wdata   = accept ? WIDTH'(ld_data) : writedata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= LOAD;
         ld_ptr_q    <= '0;
         ld_ready_q  <= 1'b1;
         cpu_reset_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         ld_ptr_q    <= ld_ptr_d;
         ld_ready_q  <= ld_ready_d;
         cpu_reset_q <= cpu_reset_d;
      end
   end

   assign state     = state_q;
   assign ld_ready  = ld_ready_q;
   assign cpu_reset = cpu_reset_q;

endmodule

// File: rtl/mips_mem_responder.sv
// Memory responder for the multicycle MIPS core: RAM, read mux, output register and store counter.
module mips_mem_responder
   import mips_mem_pkg::*;
#(
   parameter int unsigned      WIDTH   = 8,
   parameter int unsigned      DEPTH   = 1 << WIDTH,
   parameter logic [WIDTH-1:0] IO_ADDR = WIDTH'(IO_ADDR_DEFAULT)
) (
   input  logic                  clk,
   input  logic                  reset,
   mips_mem_if.slave             bus,
   output logic                  cpu_reset,
   output logic [WIDTH-1:0]      out_port,
   output logic                  out_strobe,
   output logic [ST_COUNT_W-1:0] st_count
);

   state_t           state;
   logic             ram_we;
   logic [WIDTH-1:0] ram_addr;
   logic [WIDTH-1:0] ram_wdata;
   logic             ld_ready;
   logic [WIDTH-1:0] ram_q [DEPTH];
   logic [WIDTH-1:0] rd_data;

   logic [WIDTH-1:0]      out_port_q, out_port_d;
   logic                  out_strobe_q, out_strobe_d;
   logic [ST_COUNT_W-1:0] st_count_q, st_count_d;
   logic                  store, io_store;

   mips_mem_loader #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .IO_ADDR (IO_ADDR)
   ) u_loader (
      .clk       (clk),
      .reset     (reset),
      .ld_valid  (bus.ld_valid),
      .ld_data   (bus.ld_data),
      .ld_last   (bus.ld_last),
      .memwrite  (bus.memwrite),
      .adr       (bus.adr),
      .writedata (bus.writedata),
      .ld_ready  (ld_ready),
      .cpu_reset (cpu_reset),
      .state     (state),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata)
   );

   // RAM is deliberately not reset so an image survives a reset that interrupts reloading.
   always_ff @(posedge clk) begin
      if (ram_we) ram_q[ram_addr] <= ram_wdata;
   end

   always_comb begin
      rd_data = '0;
      if ((state == RUN) && bus.memread)
         rd_data = (bus.adr == IO_ADDR) ? out_port_q : ram_q[bus.adr];
      store        = (state == RUN) && bus.memwrite;
      io_store     = store && (bus.adr == IO_ADDR);
      out_port_d   = io_store ? bus.writedata : out_port_q;
      out_strobe_d = io_store;
      st_count_d   = (store && (st_count_q != '1)) ? st_count_q + ST_COUNT_W'(1) : st_count_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_port_q   <= '0;
         out_strobe_q <= 1'b0;
         st_count_q   <= '0;
      end else begin
         out_port_q   <= out_port_d;
         out_strobe_q <= out_strobe_d;
         st_count_q   <= st_count_d;
      end
   end

   assign bus.memdata  = rd_data;
   assign bus.ld_ready = ld_ready;
   assign out_port     = out_port_q;
   assign out_strobe   = out_strobe_q;
   assign st_count     = st_count_q;

endmodule
